// File: rtl/mem_arbiter.sv
// Three-master arbiter for the single-port minisoc RAM: dbg has fixed priority,
// ibus/dbus alternate round-robin; read data is steered back by a registered owner tag.
module mem_arbiter #(
    parameter int unsigned RAM_AW = 12,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              ibus_req_i,
    input  logic              ibus_we_i,
    input  logic [31:0]       ibus_addr_i,
    input  logic [31:0]       ibus_wdata_i,
    input  logic [3:0]        ibus_wstrb_i,
    output logic              ibus_gnt_o,
    output logic              ibus_rvalid_o,
    output logic [31:0]       ibus_rdata_o,

    input  logic              dbus_req_i,
    input  logic              dbus_we_i,
    input  logic [31:0]       dbus_addr_i,
    input  logic [31:0]       dbus_wdata_i,
    input  logic [3:0]        dbus_wstrb_i,
    output logic              dbus_gnt_o,
    output logic              dbus_rvalid_o,
    output logic [31:0]       dbus_rdata_o,

    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [31:0]       dbg_addr_i,
    input  logic [31:0]       dbg_wdata_i,
    input  logic [3:0]        dbg_wstrb_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [31:0]       dbg_rdata_o,

    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,

    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic RR_IBUS = 1'b0;
    localparam logic RR_DBUS = 1'b1;

    localparam int unsigned NUM_M = 3;
    localparam int unsigned M_IBUS = 0;
    localparam int unsigned M_DBUS = 1;
    localparam int unsigned M_DBG  = 2;

    logic                 rr_last_q, rr_last_d;
    logic [NUM_M-1:0]     rvalid_q, rvalid_d;
    logic [CNT_W-1:0]     stall_q, stall_d;

    logic                 ibus_gnt, dbus_gnt, dbg_gnt;
    logic                 sel_we;
    logic [31:0]          sel_addr;
    logic [31:0]          sel_wdata;
    logic [3:0]           sel_wstrb;
    logic                 stall_hit;

    // Arbitration: dbg first, then round-robin between the two core ports.
    always_comb begin
        ibus_gnt = 1'b0;
        dbus_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (!rst_i) begin
            if (dbg_req_i) begin
                dbg_gnt = 1'b1;
            end else if (ibus_req_i && dbus_req_i) begin
                if (rr_last_q == RR_DBUS) begin
                    ibus_gnt = 1'b1;
                end else begin
                    dbus_gnt = 1'b1;
                end
            end else if (ibus_req_i) begin
                ibus_gnt = 1'b1;
            end else if (dbus_req_i) begin
                dbus_gnt = 1'b1;
            end
        end
    end

    // Route the winning master's fields onto the RAM port.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = 32'h0;
        sel_wdata = 32'h0;
        sel_wstrb = 4'h0;
        if (dbg_gnt) begin
            sel_we    = dbg_we_i;
            sel_addr  = dbg_addr_i;
            sel_wdata = dbg_wdata_i;
            sel_wstrb = dbg_wstrb_i;
        end else if (ibus_gnt) begin
            sel_we    = ibus_we_i;
            sel_addr  = ibus_addr_i;
            sel_wdata = ibus_wdata_i;
            sel_wstrb = ibus_wstrb_i;
        end else if (dbus_gnt) begin
            sel_we    = dbus_we_i;
            sel_addr  = dbus_addr_i;
            sel_wdata = dbus_wdata_i;
            sel_wstrb = dbus_wstrb_i;
        end
    end

    assign ram_en_o    = ibus_gnt | dbus_gnt | dbg_gnt;
    assign ram_we_o    = sel_we ? sel_wstrb : 4'b0000;
    assign ram_addr_o  = sel_addr[RAM_AW+1:2];
    assign ram_wdata_o = sel_wdata;

    // Next-state: round-robin pointer, read owner tag, saturating stall count.
    always_comb begin
        rr_last_d = rr_last_q;
        if (ibus_gnt) begin
            rr_last_d = RR_IBUS;
        end else if (dbus_gnt) begin
            rr_last_d = RR_DBUS;
        end

        rvalid_d         = '0;
        rvalid_d[M_IBUS] = ibus_gnt & ~ibus_we_i;
        rvalid_d[M_DBUS] = dbus_gnt & ~dbus_we_i;
        rvalid_d[M_DBG]  = dbg_gnt  & ~dbg_we_i;

        stall_hit = (ibus_req_i & ~ibus_gnt) | (dbus_req_i & ~dbus_gnt);
        stall_d   = stall_q;
        if (stall_hit && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_last_q <= RR_DBUS;
            rvalid_q  <= '0;
            stall_q   <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            rvalid_q  <= rvalid_d;
            stall_q   <= stall_d;
        end
    end

    assign ibus_gnt_o = ibus_gnt;
    assign dbus_gnt_o = dbus_gnt;
    assign dbg_gnt_o  = dbg_gnt;

    // A read response due in a reset cycle is dropped, not delivered late.
    assign ibus_rvalid_o = rvalid_q[M_IBUS] & ~rst_i;
    assign dbus_rvalid_o = rvalid_q[M_DBUS] & ~rst_i;
    assign dbg_rvalid_o  = rvalid_q[M_DBG]  & ~rst_i;

    assign ibus_rdata_o = ram_rdata_i;
    assign dbus_rdata_o = ram_rdata_i;
    assign dbg_rdata_o  = ram_rdata_i;

    assign stall_cnt_o = stall_q;

    // Upper address bits alias and byte-offset bits are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ibus_addr_i[31:RAM_AW+2], ibus_addr_i[1:0],
                                dbus_addr_i[31:RAM_AW+2], dbus_addr_i[1:0],
                                dbg_addr_i[31:RAM_AW+2],  dbg_addr_i[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a word-level memory model predicts
// grants, RAM port fields, read data routing and the saturating stall count.
module tb_mem_arbiter;

    localparam int unsigned RAM_AW  = 12;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned DEPTH   = 1 << RAM_AW;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        ibus_req, ibus_we, ibus_gnt, ibus_rvalid;
    logic [31:0] ibus_addr, ibus_wdata, ibus_rdata;
    logic [3:0]  ibus_wstrb;
    logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_wstrb;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [3:0]  dbg_wstrb;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'h0;
    logic [CNT_W-1:0]  stall_cnt;

    mem_arbiter #(.RAM_AW(RAM_AW), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .ibus_req_i(ibus_req), .ibus_we_i(ibus_we), .ibus_addr_i(ibus_addr),
        .ibus_wdata_i(ibus_wdata), .ibus_wstrb_i(ibus_wstrb), .ibus_gnt_o(ibus_gnt),
        .ibus_rvalid_o(ibus_rvalid), .ibus_rdata_o(ibus_rdata),
        .dbus_req_i(dbus_req), .dbus_we_i(dbus_we), .dbus_addr_i(dbus_addr),
        .dbus_wdata_i(dbus_wdata), .dbus_wstrb_i(dbus_wstrb), .dbus_gnt_o(dbus_gnt),
        .dbus_rvalid_o(dbus_rvalid), .dbus_rdata_o(dbus_rdata),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_wstrb_i(dbg_wstrb), .dbg_gnt_o(dbg_gnt),
        .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural single-port RAM driven by the DUT's RAM port.
    logic [31:0] ram_mem [DEPTH];
    bit ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < int'(DEPTH); i++) ram_mem[i] <= init_word(i);
            ram_init <= 1'b1;
        end else if (ram_en === 1'b1) begin
            if (ram_we == 4'b0000) begin
                ram_rdata <= ram_mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Reference model state: master intent, word memory, rr pointer, stall count.
    logic [31:0] ref_mem [DEPTH];
    bit          act [3];
    bit          wen [3];
    logic [31:0] ad  [3];
    logic [31:0] wd  [3];
    logic [3:0]  st  [3];
    int          rr_last   = 1;
    int          exp_stall = 0;

    typedef struct {
        int          mst;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t sb [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        ibus_req = act[0]; ibus_we = wen[0]; ibus_addr = ad[0]; ibus_wdata = wd[0]; ibus_wstrb = st[0];
        dbus_req = act[1]; dbus_we = wen[1]; dbus_addr = ad[1]; dbus_wdata = wd[1]; dbus_wstrb = st[1];
        dbg_req  = act[2]; dbg_we  = wen[2]; dbg_addr  = ad[2]; dbg_wdata  = wd[2]; dbg_wstrb  = st[2];
    endtask

    task automatic arm(input int m, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        act[m] = 1'b1; wen[m] = w; ad[m] = a; wd[m] = d; st[m] = s;
    endtask

    // One clock cycle: drive, predict and compare the combinational grant path,
    // then advance the model and compare the registered stall count.
    task automatic do_cycle(input bit rst_v);
        int g;
        int w;
        bit stall_hit;
        rst = rst_v;
        drive_inputs();
        #1;
        g = -1;
        if (!rst_v) begin
            if (act[2])                   g = 2;
            else if (act[0] && act[1])    g = (rr_last == 1) ? 0 : 1;
            else if (act[0])              g = 0;
            else if (act[1])              g = 1;
        end
        check("gnt", {29'b0, dbg_gnt, dbus_gnt, ibus_gnt}, (g < 0) ? 32'h0 : (32'(1) << g));
        check("ram_en", 32'(ram_en), 32'(g >= 0));
        stall_hit = (act[0] && g != 0) || (act[1] && g != 1);
        if (g >= 0) begin
            w = int'((ad[g] >> 2) % DEPTH);
            check("ram_addr", 32'(ram_addr), 32'(w));
            check("ram_we", 32'(ram_we), wen[g] ? 32'(st[g]) : 32'h0);
            check("ram_wdata", ram_wdata, wd[g]);
            if (wen[g]) begin
                for (int b = 0; b < 4; b++)
                    if (st[g][b]) ref_mem[w][8*b +: 8] = wd[g][8*b +: 8];
            end else begin
                sb.push_back('{g, ref_mem[w], cyc + 1});
            end
            if (g < 2) rr_last = g;
            act[g] = 1'b0;
        end
        if (rst_v) begin
            exp_stall = 0;
            rr_last   = 1;
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].due == cyc) sb.delete(i);
        end else if (stall_hit && exp_stall < int'(CNT_MAX)) begin
            exp_stall++;
        end
        @(posedge clk);
        #1;
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    endtask

    task automatic drain();
        int n = 0;
        while ((act[0] || act[1] || act[2]) && n < 20) begin
            do_cycle(1'b0);
            n++;
        end
        if (act[0] || act[1] || act[2]) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: requests still pending after %0d cycles", n);
            act[0] = 1'b0; act[1] = 1'b0; act[2] = 1'b0;
        end
        do_cycle(1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] word;
        case ($urandom_range(3))
            0:       word = 32'(DEPTH - 1 - $urandom_range(7));
            1, 2:    word = 32'($urandom_range(15));
            default: return $urandom;
        endcase
        return (32'($urandom_range(7)) << (RAM_AW + 2)) | (word << 2) | 32'($urandom_range(3));
    endfunction

    // Monitor: pops the scoreboard whenever any master sees rvalid.
    always @(negedge clk) begin
        logic [2:0]  vld;
        logic [31:0] rd;
        rsp_t        e;
        vld = {dbg_rvalid === 1'b1, dbus_rvalid === 1'b1, ibus_rvalid === 1'b1};
        if (vld != 3'b000) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rvalid: got rvalid %b expected none (cycle %0d)", vld, cyc);
            end else begin
                e  = sb.pop_front();
                rd = (e.mst == 0) ? ibus_rdata : (e.mst == 1) ? dbus_rdata : dbg_rdata;
                check("rvalid_owner", 32'(vld), 32'(1) << e.mst);
                check("rvalid_cycle", 32'(cyc), 32'(e.due));
                check("rdata", rd, e.data);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_rvalid: got none expected master %0d data %h (cycle %0d)",
                     e.mst, e.data, cyc);
        end
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
        for (int m = 0; m < 3; m++) begin
            act[m] = 1'b0; wen[m] = 1'b0; ad[m] = 32'h0; wd[m] = 32'h0; st[m] = 4'h0;
        end
        drive_inputs();
        @(posedge clk);
        #1;

        // Reset held with every master requesting.
        arm(0, 1'b0, 32'h40, 32'h0, 4'h0);
        arm(1, 1'b0, 32'h44, 32'h0, 4'h0);
        arm(2, 1'b0, 32'h48, 32'h0, 4'h0);
        repeat (3) do_cycle(1'b1);
        drain();

        // Single ibus read.
        do_cycle(1'b1);
        arm(0, 1'b0, 32'h10, 32'h0, 4'h0);
        do_cycle(1'b0);
        do_cycle(1'b0);

        // ibus/dbus contention from reset: I, D, I, D.
        do_cycle(1'b1);
        for (int k = 0; k < 4; k++) begin
            if (!act[0]) arm(0, 1'b0, 32'(k) << 2, 32'h0, 4'h0);
            if (!act[1]) arm(1, 1'b0, 32'h100 + (32'(k) << 2), 32'h0, 4'h0);
            do_cycle(1'b0);
        end
        check("contention_stall", 32'(stall_cnt), 32'd4);
        drain();

        // dbg write beats both core ports; merged bytes read back.
        arm(0, 1'b0, 32'h20, 32'h0, 4'h0);
        arm(1, 1'b0, 32'h24, 32'h0, 4'h0);
        arm(2, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'b0011);
        drain();
        arm(0, 1'b0, 32'h8, 32'h0, 4'h0);
        drain();

        // Address aliasing at both ends of the word range.
        arm(1, 1'b0, 32'h4000, 32'h0, 4'h0);
        drain();
        arm(1, 1'b0, 32'h3FFC, 32'h0, 4'h0);
        drain();

        // Reset right after a read grant drops the response.
        arm(0, 1'b0, 32'h30, 32'h0, 4'h0);
        do_cycle(1'b0);
        do_cycle(1'b1);
        do_cycle(1'b0);
        do_cycle(1'b0);

        // Sustained contention saturates the stall counter.
        do_cycle(1'b1);
        for (int k = 0; k < 70; k++) begin
            if (!act[0]) arm(0, 1'b0, rand_addr(), 32'h0, 4'h0);
            if (!act[1]) arm(1, 1'b0, rand_addr(), 32'h0, 4'h0);
            do_cycle(1'b0);
        end
        check("stall_saturated", 32'(stall_cnt), 32'(CNT_MAX));
        drain();

        // Randomized traffic with occasional resets.
        do_cycle(1'b1);
        for (int k = 0; k < 3000; k++) begin
            for (int m = 0; m < 3; m++) begin
                if (!act[m] && $urandom_range(99) < ((m == 2) ? 10 : 60))
                    arm(m, $urandom_range(9) < 4, rand_addr(), $urandom,
                        4'($urandom_range(15, 1)));
            end
            do_cycle($urandom_range(199) == 0);
        end
        drain();
        repeat (3) do_cycle(1'b0);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_responses: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
